// File: rtl/vlc_decode_pkg.sv
// Shared definitions for the VLC run-length decoder: field sizes and FSM encoding.
package vlc_decode_pkg;

  localparam int THIRD_FIELD_SIZE = 4;
  localparam int VLC_DEC_DEPTH    = 4;

  typedef enum logic {
    VLC_DEC_IDLE = 1'b0,
    VLC_DEC_EMIT = 1'b1
  } dec_state_e;

endpackage

// File: rtl/vlc_token_fifo.sv
// Show-ahead token FIFO with registered occupancy, full and empty flags.
module vlc_token_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;

  // Writer never pushes when full and reader never pops when empty.
  always_comb begin
    count_nxt = count;
    if (wr_en && !rd_en)      count_nxt = count + 1'b1;
    else if (!wr_en && rd_en) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/vlc_decode.sv
// Run-length decoder: expands queued {type, count} tokens into a serial bit stream.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
module vlc_decode
  import vlc_decode_pkg::*;
#(
  parameter int CNT_W = THIRD_FIELD_SIZE,
  parameter int DEPTH = VLC_DEC_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             type_of_occurrence,
  input  logic [CNT_W-1:0] data_in,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             data_out,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             run_last,
  output logic             err_zero_len,
  output dec_state_e       state_dbg
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  dec_state_e       state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W:0]   head;
  logic             head_type;
  logic [CNT_W-1:0] head_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             ready_en;
  logic             head_seen;

  assign head_type = head[CNT_W];
  assign head_cnt  = head[CNT_W-1:0];
  assign din_ready = ready_en & ~fifo_full;
  assign state_dbg = state;

  vlc_token_fifo #(
    .WIDTH(CNT_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (din_valid & din_ready),
    .wr_data({type_of_occurrence, data_in}),
    .rd_en  (pop),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Idle pick-up waits until a token has sat in the FIFO for a cycle (head_seen),
  // giving the two-edge accept-to-output latency; in EMIT the next token is
  // taken on the same edge as the last bit so runs stay contiguous.
  always_comb begin
    pop = 1'b0;
    case (state)
      VLC_DEC_IDLE: pop = head_seen & ~fifo_empty;
      VLC_DEC_EMIT: pop = dout_ready & (remaining == ONE) & ~fifo_empty;
      default:      pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= VLC_DEC_IDLE;
      remaining    <= '0;
      data_out     <= 1'b0;
      dout_valid   <= 1'b0;
      run_last     <= 1'b0;
      err_zero_len <= 1'b0;
      ready_en     <= 1'b0;
      head_seen    <= 1'b0;
    end else begin
      ready_en     <= 1'b1;
      head_seen    <= ~fifo_empty;
      err_zero_len <= 1'b0;
      case (state)
        VLC_DEC_IDLE: begin
          if (pop) begin
            if (head_cnt != '0) begin
              state      <= VLC_DEC_EMIT;
              data_out   <= head_type;
              remaining  <= head_cnt;
              dout_valid <= 1'b1;
              run_last   <= (head_cnt == ONE);
            end else begin
              err_zero_len <= 1'b1;
            end
          end
        end
        VLC_DEC_EMIT: begin
          if (dout_ready) begin
            if (remaining != ONE) begin
              remaining <= remaining - ONE;
              run_last  <= (remaining == TWO);
            end else if (pop && head_cnt != '0) begin
              data_out  <= head_type;
              remaining <= head_cnt;
              run_last  <= (head_cnt == ONE);
            end else begin
              state        <= VLC_DEC_IDLE;
              data_out     <= 1'b0;
              dout_valid   <= 1'b0;
              run_last     <= 1'b0;
              err_zero_len <= pop;
            end
          end
        end
        default: state <= VLC_DEC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vlc_decode.sv
// Bench for vlc_decode: token table, hand-written corner sequences and random traffic.
module tb_vlc_decode;
  import vlc_decode_pkg::*;

  localparam int CNT_W = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             typ = 1'b0;
  logic [CNT_W-1:0] data_in = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic             data_out;
  logic             dout_valid;
  logic             dout_ready = 1'b1;
  logic             run_last;
  logic             err_zero_len;
  dec_state_e       state_dbg;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int exp_err = 0;
  bit rand_ready = 1'b0;

  // Each entry is {bit value, last-of-run flag}.
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  typedef struct {
    logic             t;
    logic [CNT_W-1:0] c;
    int               exp_bits;
    int               exp_errs;
  } vec_t;

  vlc_decode #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .type_of_occurrence(typ),
    .data_in           (data_in),
    .din_valid         (din_valid),
    .din_ready         (din_ready),
    .data_out          (data_out),
    .dout_valid        (dout_valid),
    .dout_ready        (dout_ready),
    .run_last          (run_last),
    .err_zero_len      (err_zero_len),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model and scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A run of n bits of value t; only the final bit is flagged last.
  task automatic model_push(input logic t, input int n);
    if (n == 0) exp_err++;
    for (int i = 0; i < n; i++) exp_q.push_back({t, (i == n - 1) ? 1'b1 : 1'b0});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (din_valid && din_ready) model_push(typ, int'(data_in));
      if (err_zero_len) err_seen++;
      if (dout_valid && dout_ready) begin
        got_q.push_back({data_out, run_last});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got bit %0d with nothing expected at %0t", data_out, $time);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("stream_bit", data_out, e[1]);
          chk("stream_last", run_last, e[0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      dout_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic send_token(input logic t, input int c);
    bit ok;
    typ       = t;
    data_in   = CNT_W'(c);
    din_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = din_ready;
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = dout_valid;
    end
    if (!seen) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 3000 && quiet < 4; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !dout_valid && state_dbg == VLC_DEC_IDLE) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[6];

  initial begin
    logic [6:0] s3_bits;
    logic [6:0] s3_last;
    logic [1:0] snap;
    int         base;
    int         nlast;
    int         nval;

    tbl[0] = '{1'b1, 4'd1,  1,  0};
    tbl[1] = '{1'b0, 4'd15, 15, 0};
    tbl[2] = '{1'b1, 4'd0,  0,  1};
    tbl[3] = '{1'b0, 4'd7,  7,  0};
    tbl[4] = '{1'b1, 4'd15, 15, 0};
    tbl[5] = '{1'b0, 4'd2,  2,  0};

    // Reset state
    #3;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_run_last", run_last, 0);
    chk("rst_err", err_zero_len, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_din_ready", din_ready, 1);
    chk("rel_dout_valid", dout_valid, 0);
    @(posedge clk);
    #1;

    // Reset in the middle of a run drops the run and the queued token
    send_token(1'b1, 15);
    send_token(1'b0, 3);
    wait_valid();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    #1;
    chk("mid_rst_dout_valid", dout_valid, 0);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_run_last", run_last, 0);
    chk("mid_rst_err", err_zero_len, 0);
    chk("mid_rst_din_ready", din_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rel_din_ready", din_ready, 1);
    chk("mid_rel_dout_valid", dout_valid, 0);
    repeat (6) @(negedge clk);
    chk("mid_rst_tokens_lost", dout_valid, 0);
    @(posedge clk);
    #1;

    // Table of single tokens
    for (int v = 0; v < 6; v++) begin
      got_q.delete();
      base = err_seen;
      send_token(tbl[v].t, int'(tbl[v].c));
      drain();
      nlast = 0;
      nval = 0;
      foreach (got_q[i]) begin
        if (got_q[i][0]) nlast++;
        if (got_q[i][1] == tbl[v].t) nval++;
      end
      chk("tbl_bits", got_q.size(), tbl[v].exp_bits);
      chk("tbl_value", nval, tbl[v].exp_bits);
      chk("tbl_last_count", nlast, (tbl[v].exp_bits > 0) ? 1 : 0);
      chk("tbl_err", err_seen - base, tbl[v].exp_errs);
    end

    // Latency and shape of a single {1,3} run
    send_token(1'b1, 3);
    @(negedge clk);
    chk("lat_k", dout_valid, 0);
    @(negedge clk);
    chk("lat_k1", dout_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("run3_valid", dout_valid, 1);
      chk("run3_bit", data_out, 1);
      chk("run3_last", run_last, (i == 2) ? 1 : 0);
    end
    @(negedge clk);
    chk("run3_end", dout_valid, 0);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back tokens form one contiguous stream
    s3_bits = 7'b0000100;
    s3_last = 7'b1000110;
    send_token(1'b0, 2);
    send_token(1'b1, 1);
    send_token(1'b0, 4);
    wait_valid();
    for (int i = 0; i < 7; i++) begin
      chk("b2b_valid", dout_valid, 1);
      chk("b2b_bit", data_out, s3_bits[i]);
      chk("b2b_last", run_last, s3_last[i]);
      @(negedge clk);
    end
    chk("b2b_end", dout_valid, 0);
    @(posedge clk);
    #1;
    drain();

    // Back-pressure: freeze mid-run and fill the FIFO
    got_q.delete();
    send_token(1'b1, 5);
    wait_valid();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    @(negedge clk);
    snap = {data_out, run_last};
    chk("hold_valid", dout_valid, 1);
    chk("hold_snapshot", snap, 2'b10);
    @(posedge clk);
    #1;
    send_token(1'b0, 3);
    send_token(1'b1, 2);
    send_token(1'b0, 1);
    send_token(1'b1, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_din_ready", din_ready, 0);
      chk("hold_frozen", {data_out, run_last}, snap);
      chk("hold_frozen_valid", dout_valid, 1);
    end
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    drain();
    chk("hold_all_bits", got_q.size(), 15);

    // Zero-length token between two runs
    got_q.delete();
    base = err_seen;
    send_token(1'b0, 1);
    send_token(1'b1, 0);
    send_token(1'b1, 2);
    drain();
    chk("zero_err_once", err_seen - base, 1);
    chk("zero_stream_len", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("zero_stream_0", got_q[0], 2'b01);
      chk("zero_stream_1", got_q[1], 2'b10);
      chk("zero_stream_2", got_q[2], 2'b11);
    end

    // Random traffic with random back-pressure
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int c;
      c = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      send_token(1'($urandom_range(0, 1)), c);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    drain();

    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_err_total", err_seen, exp_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
